// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS data-memory responder slice.
//   - dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_BYTES   : bytes per 32-bit word
//   - index_width(): word-index width for a given DEPTH_WORDS
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

    // Width of the word index into a DEPTH_WORDS-deep array.
    function automatic int index_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
//   Load/store bus between the core (master) and the data-memory responder
//   (slave).
//   master -> slave : memRead_in, memWrite_in, address_in, writeData_in
//   slave -> master : readData_out, ready_out, busy_out, error_out
//   With DMEM_STATS_EN defined the slave also returns loadCount_out and
//   storeCount_out (16-bit saturating access counters).
// ----------------------------------------------------------------------------
interface dmem_responder_if;

    logic        memRead_in;
    logic        memWrite_in;
    logic [31:0] address_in;
    logic [31:0] writeData_in;
    logic [31:0] readData_out;
    logic        ready_out;
    logic        busy_out;
    logic        error_out;
`ifdef DMEM_STATS_EN
    logic [15:0] loadCount_out;
    logic [15:0] storeCount_out;
`endif

    modport master (
        output memRead_in,
        output memWrite_in,
        output address_in,
        output writeData_in,
        input  readData_out,
        input  ready_out,
        input  busy_out,
`ifdef DMEM_STATS_EN
        input  loadCount_out,
        input  storeCount_out,
`endif
        input  error_out
    );

    modport slave (
        input  memRead_in,
        input  memWrite_in,
        input  address_in,
        input  writeData_in,
        output readData_out,
        output ready_out,
        output busy_out,
`ifdef DMEM_STATS_EN
        output loadCount_out,
        output storeCount_out,
`endif
        output error_out
    );

endinterface

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
//   Single-port word storage, synchronous write and registered read
//   (read-before-write on the same index). Contents are never reset.
//   Ports:
//     clock_in  - clock, rising edge
//     we_in     - write enable
//     index_in  - word index
//     data_in   - write data
//     data_out  - registered read data of index_in
// ----------------------------------------------------------------------------
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_W     = index_width(DEPTH_WORDS)
) (
    input  logic                  clock_in,
    input  logic                  we_in,
    input  logic [INDEX_W-1:0]    index_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock_in) begin
        if (we_in) begin
            mem[index_in] <= data_in;
        end
        data_out <= mem[index_in];
    end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the load/store side of the MIPS datapath.
//   A request (memRead_in or memWrite_in) is captured in IDLE, serviced after
//   LATENCY wait cycles and completed with a one-cycle ready_out pulse.
//   Misaligned addresses and simultaneous read+write are rejected: they still
//   complete, but with error_out high, no array write and readData_out held.
//   Ports:
//     clock_in    - clock, rising edge
//     reset_n_in  - asynchronous active-low reset (storage is not cleared)
//     bus         - dmem_responder_if.slave request/response bus
//   Optional feature macro: DMEM_STATS_EN adds loadCount_out/storeCount_out,
//   saturating counts of successful loads and stores.
// ----------------------------------------------------------------------------
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    dmem_responder_if.slave   bus
);

    localparam int INDEX_W = index_width(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    // Counter preload on entering WAIT; unused when LATENCY is 0.
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]            state_reg,  state_next;
    logic [3:0]            count_reg,  count_next;
    logic [INDEX_W-1:0]    index_reg,  index_next;
    logic [DATA_WIDTH-1:0] wdata_reg,  wdata_next;
    logic                  is_load_reg, is_load_next;
    logic                  err_reg,    err_next;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic                  access;
    logic                  array_we;
    logic [DATA_WIDTH-1:0] array_dout;

    logic                  req;
    logic                  req_bad;
    logic [INDEX_W-1:0]    req_index;
    logic                  ready;
    logic                  load_ok;

    // Upper address bits wrap; they are intentionally ignored.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^bus.address_in[31:INDEX_W+2];

    assign req       = bus.memRead_in | bus.memWrite_in;
    assign req_bad   = (bus.address_in[1:0] != 2'b00) |
                       (bus.memRead_in & bus.memWrite_in);
    assign req_index = bus.address_in[INDEX_W+1:2];

    // ------------------------------------------------------------------
    // Next-state logic. In IDLE the *_next values carry the live request,
    // elsewhere they hold the captured one, so the array can always be fed
    // from *_next: with LATENCY=0 the access happens on the capture edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        index_next   = index_reg;
        wdata_next   = wdata_reg;
        is_load_next = is_load_reg;
        err_next     = err_reg;
        access       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    index_next   = req_index;
                    wdata_next   = bus.writeData_in;
                    is_load_next = bus.memRead_in;
                    err_next     = req_bad;
                    if (LATENCY == 0) begin
                        access     = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        count_next = LAT_M1;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (count_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign array_we = access & ~is_load_next & ~err_next;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg   <= S_IDLE;
            count_reg   <= 4'd0;
            index_reg   <= '0;
            wdata_reg   <= '0;
            is_load_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            index_reg   <= index_next;
            wdata_reg   <= wdata_next;
            is_load_reg <= is_load_next;
            err_reg     <= err_next;
        end
    end

    // The array read register captures the load data at the access edge and
    // presents it during RESP; rdata_reg keeps it afterwards so the output
    // holds until the next successful load.
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_W     (INDEX_W)
    ) u_array (
        .clock_in (clock_in),
        .we_in    (array_we),
        .index_in (index_next),
        .data_in  (wdata_next),
        .data_out (array_dout)
    );

    assign ready   = (state_reg == S_RESP);
    assign load_ok = ready & is_load_reg & ~err_reg;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rdata_reg <= '0;
        end else if (load_ok) begin
            rdata_reg <= array_dout;
        end
    end

    assign bus.readData_out = load_ok ? array_dout : rdata_reg;
    assign bus.ready_out    = ready;
    assign bus.busy_out     = (state_reg != S_IDLE);
    assign bus.error_out    = ready & err_reg;

`ifdef DMEM_STATS_EN
    logic        store_ok;
    logic [15:0] load_count_reg;
    logic [15:0] store_count_reg;

    assign store_ok = ready & ~is_load_reg & ~err_reg;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            load_count_reg  <= 16'd0;
            store_count_reg <= 16'd0;
        end else begin
            if (load_ok && load_count_reg != 16'hFFFF) begin
                load_count_reg <= load_count_reg + 16'd1;
            end
            if (store_ok && store_count_reg != 16'hFFFF) begin
                store_count_reg <= store_count_reg + 16'd1;
            end
        end
    end

    assign bus.loadCount_out  = load_count_reg;
    assign bus.storeCount_out = store_count_reg;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the load/store side of the single-cycle MIPS datapath.
- Consumes the memRead/memWrite strobes from the main control decoder, plus the ALU address and rt write data.
- Services each request after a programmable wait latency and signals completion with a one-cycle ready pulse, which the core uses as its stall release.
- Holds word-addressed storage and flags protocol and alignment errors.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two.
- LATENCY, 2, wait cycles between request capture and ready; 0..15.
- DATA_WIDTH, 32, word width; fixed at 32 for MIPS.

Ports:
- clock_in  input  1  single clock, rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- memRead_in  input  1  load request (lw).
- memWrite_in  input  1  store request (sw).
- address_in  input  32  byte address from ALU result.
- writeData_in  input  32  store data.
- readData_out  output  32  load data; valid while ready_out is high, then held.
- ready_out  output  1  one-cycle completion pulse.
- busy_out  output  1  high from the cycle after capture until ready_out drops.
- error_out  output  1  high with ready_out when the request was rejected.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State goes to IDLE; counter to 0.
  - readData_out=0, ready_out=0, busy_out=0, error_out=0.
  - Storage array is NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If memRead_in|memWrite_in is high at a rising edge, capture address, data and kind.
  - If LATENCY>0, go to WAIT with counter=LATENCY-1. If LATENCY=0, go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, perform the access at that edge and go to RESP.
  - For LATENCY=0 the access occurs on the capture edge.
- RESP:
  - ready_out=1 for exactly one cycle, then return to IDLE.
  - Inputs are ignored in RESP and WAIT; requests while busy are dropped.
  - The initiator must deassert its strobe in the cycle after ready_out. A strobe still high in IDLE is a new request.
- Total latency: capture edge to ready_out high is LATENCY+1 cycles.
- Word index is address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Rejected requests (complete normally with error_out=1, no array write, readData_out unchanged):
  - Misaligned address: address[1:0]!=0.
  - Both memRead_in and memWrite_in high in the same capture cycle.
- Store: the array word is written at the access edge; readData_out is unchanged.
- Load: readData_out is registered at the access edge and holds until the next successful load.
- Reset mid-transaction aborts it:
  - Any pending write that has not reached its access edge is lost.
  - ready_out never pulses for the aborted request.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds outputs loadCount_out[15:0] and storeCount_out[15:0].
  - Each counts successful accesses, saturating at 16'hFFFF.
  - Each increments in the ready_out cycle; errors are not counted.
  - Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - dmem_state_t enum {IDLE, WAIT, RESP}.
  - WORD_BYTES=4.
  - Localparam helper for the index width, $clog2(DEPTH_WORDS).
- Sub-module dmem_array:
  - Synchronous write, synchronous read, single port.
  - Ports: clock_in, we_in, index_in, data_in, data_out.
- dmem_responder holds the FSM, latency counter, error checks and optional statistics.

Test Plan:
- Store then load, LATENCY=2: sw 0x0000_0010 data 0xDEAD_BEEF, then ready_out 3 cycles after capture. Then lw 0x10: ready_out after 3 cycles, readData_out=0xDEAD_BEEF, error_out=0.
- LATENCY=0: lw at 0x0 → ready_out on the next cycle. Back-to-back requests: a strobe held high after ready_out gives a second capture in IDLE and a second ready 2 cycles later.
- Misaligned sw at 0x0000_0012 → ready_out and error_out high together. A following lw at 0x10 returns the old data, proving no write occurred.
- Both strobes high at address 0x20 → error_out=1 and no array change. Strobes toggled during WAIT are ignored; busy_out stays 1 until RESP ends.
- Wrap-around, DEPTH_WORDS=256: sw 0x0000_0400 data 0x1234_5678, then lw 0x0 → 0x1234_5678.
- Mid-operation reset: assert reset_n_in=0 during WAIT of an sw to 0x30. Outputs go to 0 immediately and no ready_out pulses. A subsequent lw 0x30 returns the pre-reset contents.
  - With DMEM_STATS_EN defined: two good loads and one errored store give loadCount_out=2, storeCount_out=0.
